dual_port_ram_reader: RTL and testbench

- Streaming read engine for dual_port_ram's read port (port_en_1 / addr_in_1 / data_out_1).
- On start, reads `length` consecutive words from `base_addr` with address wrap-around.
- Emits the words on a valid/ready stream with full backpressure support, then pulses done.
- Acts as the consumer counterpart to the port-0 write path that fills the RAM.

---
 rtl/dual_port_ram_reader_pkg.sv | 14 +
 rtl/dual_port_ram_reader_skid.sv | 54 +++++
 rtl/dual_port_ram_reader.sv | 128 ++++++++++++
 tb/tb_dual_port_ram_reader.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dual_port_ram_reader_pkg.sv
// Shared types and sizing for the dual_port_ram streaming reader.
// The state encoding and skid-buffer depth are used by the top and its FIFO.
package dual_port_ram_reader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } state_t;

   localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/dual_port_ram_reader_skid.sv
// Two-entry FIFO that holds {last, data} words.
// It covers the one-cycle RAM read latency while the consumer stalls.
module ram_rd_skid
   import dual_port_ram_reader_pkg::*;
#(
   parameter int WIDTH = 9
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] r_mem [BUF_DEPTH];
   logic             r_wrPtr;
   logic             r_rdPtr;
   logic [1:0]       r_count;

   // With two entries the pointers are single bits that simply toggle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wrPtr] <= i_data;
            r_wrPtr        <= ~r_wrPtr;
         end
         if (i_pop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rdPtr];
   assign o_empty = (r_count == 2'd0);
   assign o_full  = (r_count == 2'(BUF_DEPTH));
   assign o_count = r_count;

endmodule

// File: rtl/dual_port_ram_reader.sv
// Streaming burst reader for the RAM read port with a valid/ready output.
// Words bypass the skid FIFO when it is empty, which keeps one beat per cycle.
module dual_port_ram_reader
   import dual_port_ram_reader_pkg::*;
#(
   parameter int addr_width = 4,
   parameter int data_width = 8,
   parameter int depth      = 16
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [addr_width-1:0] base_addr,
   input  logic [addr_width:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_port_en,
   output logic [addr_width-1:0] ram_addr,
   input  logic [data_width-1:0] ram_data,
   output logic [data_width-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last
);

   localparam logic [addr_width:0]   LEN_MAX  = (addr_width+1)'(depth);
   localparam logic [addr_width:0]   LEN_ONE  = (addr_width+1)'(1);
   localparam logic [addr_width-1:0] ADDR_ONE = addr_width'(1);

   state_t                r_state;
   state_t                w_nextState;
   logic [addr_width-1:0] r_baseAddr;
   logic [addr_width-1:0] r_issued;
   logic [addr_width-1:0] r_addrHold;
   logic [addr_width-1:0] w_issueAddr;
   logic [addr_width:0]   r_remain;
   logic [addr_width:0]   w_lenSat;
   logic                  r_inflight;
   logic                  r_inflightLast;
   logic                  w_issue;
   logic                  w_lastIssue;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_fire;
   logic                  w_full;
   logic                  w_empty;
   logic [1:0]            w_count;
   logic [data_width:0]   w_head;

   assign w_lenSat    = (length > LEN_MAX) ? LEN_MAX : length;
   assign w_issueAddr = r_baseAddr + r_issued;

   // Never let in-flight plus buffered words exceed the two FIFO slots.
   assign w_issue     = (r_state == READ) && (r_remain != '0) && !w_full &&
                        ((2'(r_inflight) + w_count) < 2'd2);
   assign w_lastIssue = w_issue && (r_remain == LEN_ONE);

   assign m_valid = !w_empty || r_inflight;
   assign m_data  = !w_empty ? w_head[data_width-1:0] : (r_inflight ? ram_data : '0);
   assign m_last  = !w_empty ? w_head[data_width] : r_inflightLast;
   assign w_fire  = m_valid && m_ready;
   assign w_pop   = !w_empty && m_ready;
   assign w_push  = r_inflight && !(w_empty && m_ready);

   assign busy        = (r_state == READ) || (r_state == DRAIN);
   assign done        = (r_state == DONE);
   assign ram_port_en = w_issue;
   assign ram_addr    = w_issue ? w_issueAddr : r_addrHold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (start) w_nextState = (length == '0) ? DONE : READ;
         READ:    if (w_lastIssue) w_nextState = DRAIN;
         DRAIN:   if (w_fire && m_last) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // The RAM output is only valid the cycle after an issue, so the in-flight
   // flag marks exactly when ram_data may be consumed or pushed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_baseAddr     <= '0;
         r_issued       <= '0;
         r_remain       <= '0;
         r_addrHold     <= '0;
         r_inflight     <= 1'b0;
         r_inflightLast <= 1'b0;
      end else begin
         r_inflight     <= w_issue;
         r_inflightLast <= w_lastIssue;
         if ((r_state == IDLE) && start) begin
            r_baseAddr <= base_addr;
            r_issued   <= '0;
            r_remain   <= w_lenSat;
         end else if (w_issue) begin
            r_issued   <= r_issued + ADDR_ONE;
            r_remain   <= r_remain - LEN_ONE;
            r_addrHold <= w_issueAddr;
         end
      end
   end

   ram_rd_skid #(
      .WIDTH (data_width + 1)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  ({r_inflightLast, ram_data}),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

endmodule

// File: tb/tb_dual_port_ram_reader.sv
// Directed bench for dual_port_ram_reader with a registered-read RAM model.
// Expected words come from the bench's own memory image, mem[i] = i + 1.
module tb_dual_port_ram_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] base_addr;
   logic [4:0] length;
   logic       busy;
   logic       done;
   logic       ram_port_en;
   logic [3:0] ram_addr;
   logic [7:0] ram_data = 8'd0;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_last;

   logic [7:0] tbMem [16];
   int         checkCount = 0;
   int         passCount  = 0;
   int         failCount  = 0;

   always #5 clk = ~clk;

   // Registered-output RAM: data appears the cycle after an enabled read.
   always @(posedge clk) begin
      if (ram_port_en) ram_data <= tbMem[ram_addr];
   end

   dual_port_ram_reader #(
      .addr_width (4),
      .data_width (8),
      .depth      (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .base_addr   (base_addr),
      .length      (length),
      .busy        (busy),
      .done        (done),
      .ram_port_en (ram_port_en),
      .ram_addr    (ram_addr),
      .ram_data    (ram_data),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_last      (m_last)
   );

   function automatic logic [31:0] outVec();
      return {15'd0, busy, done, ram_port_en, ram_addr, m_valid, m_last, m_data};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Runs one burst. readyMode 0 keeps m_ready high, 1 uses the 1,0,0 pattern.
   // abortAfter > 0 asserts reset after that many beats; intrudeAt > 0 pulses
   // a conflicting start on that cycle.
   task automatic applyStimulus(input logic [3:0] base, input logic [4:0] len,
                                input int readyMode, input int abortAfter,
                                input int intrudeAt, input string tag);
      int   expBeats;
      int   beats = 0, issues = 0, dones = 0, maxOut = 0;
      int   stableErrs = 0, busyErrs = 0, firstCyc = 0, lastCyc = 0;
      bit   finished = 0, aborted = 0, prevStall = 0;
      logic [7:0] prevData = 8'd0;
      logic prevLast = 1'b0;
      expBeats = (len > 5'd16) ? 16 : int'(len);
      @(negedge clk);
      base_addr = base;
      length    = len;
      start     = 1'b1;
      for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (intrudeAt != 0 && cyc == intrudeAt) begin
            start     = 1'b1;
            base_addr = base + 4'd7;
            length    = 5'd3;
         end
         m_ready = (readyMode == 0) ? 1'b1 : (((cyc - 1) % 3) == 0);
         if (cyc == 1) checkOutput({tag, "_validCyc1"}, 32'(m_valid), 32'd0);
         if (cyc == 2 && expBeats > 0) checkOutput({tag, "_validCyc2"}, 32'(m_valid), 32'd1);
         if (prevStall && !(m_valid && m_data === prevData && m_last === prevLast))
            stableErrs++;
         if (ram_port_en) begin
            checkOutput({tag, "_addr"}, 32'(ram_addr), 32'((int'(base) + issues) % 16));
            issues++;
         end
         if (issues - beats > maxOut) maxOut = issues - beats;
         if (!done && expBeats > 0 && busy !== 1'b1) busyErrs++;
         if (m_valid && m_ready) begin
            checkOutput({tag, "_data"}, 32'(m_data), 32'(((int'(base) + beats) % 16) + 1));
            checkOutput({tag, "_last"}, 32'(m_last), 32'(beats == expBeats - 1));
            if (beats == 0) firstCyc = cyc;
            lastCyc = cyc;
            beats++;
            if (abortAfter != 0 && beats == abortAfter) begin
               @(posedge clk);
               #1 rst = 1'b1;
               #1 checkOutput({tag, "_asyncReset"}, outVec(), 32'd0);
               aborted  = 1;
               finished = 1;
            end
         end
         prevStall = m_valid && !m_ready;
         prevData  = m_data;
         prevLast  = m_last;
         if (done) begin
            dones++;
            checkOutput({tag, "_busyAtDone"}, 32'(busy), 32'd0);
            finished = 1;
         end
      end
      if (aborted) begin
         @(negedge clk);
         rst = 1'b0;
         checkOutput({tag, "_idleAfterReset"}, outVec(), 32'd0);
      end else begin
         checkOutput({tag, "_beats"}, 32'(beats), 32'(expBeats));
         checkOutput({tag, "_issues"}, 32'(issues), 32'(expBeats));
         checkOutput({tag, "_doneCount"}, 32'(dones), 32'd1);
         checkOutput({tag, "_outstandingLe2"}, 32'(maxOut <= 2), 32'd1);
         checkOutput({tag, "_stallStable"}, 32'(stableErrs), 32'd0);
         checkOutput({tag, "_busyHigh"}, 32'(busyErrs), 32'd0);
         if (readyMode == 0 && expBeats > 0)
            checkOutput({tag, "_backToBack"}, 32'(lastCyc - firstCyc), 32'(expBeats - 1));
         @(negedge clk);
         checkOutput({tag, "_donePulse"}, 32'({done, busy}), 32'd0);
      end
      m_ready = 1'b1;
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = 4'd0;
      length    = 5'd0;
      m_ready   = 1'b1;
      for (int i = 0; i < 16; i++) tbMem[i] = 8'(i + 1);
      #12;
      checkOutput("resetAsserted", outVec(), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("resetReleased", outVec(), 32'd0);

      $display("[TB] full burst base=0 len=16");
      applyStimulus(4'd0, 5'd16, 0, 0, 0, "full");
      $display("[TB] wrap burst base=14 len=4");
      applyStimulus(4'd14, 5'd4, 0, 0, 0, "wrap");
      $display("[TB] backpressure base=2 len=6");
      applyStimulus(4'd2, 5'd6, 1, 0, 0, "stall");
      $display("[TB] zero length");
      applyStimulus(4'd3, 5'd0, 0, 0, 0, "len0");
      $display("[TB] saturated length 20");
      applyStimulus(4'd7, 5'd20, 0, 0, 0, "len20");
      $display("[TB] reset after third beat");
      applyStimulus(4'd0, 5'd10, 0, 3, 0, "abort");
      applyStimulus(4'd5, 5'd2, 0, 0, 0, "afterAbort");
      $display("[TB] start while busy");
      applyStimulus(4'd3, 5'd5, 0, 0, 3, "intrude");
      applyStimulus(4'd9, 5'd3, 1, 0, 0, "stallShort");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
